// File: rtl/tiny5_dmem_responder.sv
// Data-memory responder for the tiny5 load/store port: one request at a time,
// programmable wait states, little-endian word array with byte-lane stores.
module tiny5_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, commit;

    logic        write_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;

    logic        cur_write;
    logic [31:0] cur_addr;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_wdata;

    logic        illegal, misaligned, out_of_range, err;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word, load_data, wr_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [3:0]  be;
    logic        mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign accept      = req_valid_i & req_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            write_q  <= 1'b0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
        end else if (accept) begin
            write_q  <= req_write_i;
            addr_q   <= req_addr_i;
            funct3_q <= req_funct3_i;
            wdata_q  <= req_wdata_i;
        end
    end

    // With no wait states the commit edge is the accepting edge, so the live request is used.
    always_comb begin
        cur_write  = (LATENCY == 0) ? req_write_i  : write_q;
        cur_addr   = (LATENCY == 0) ? req_addr_i   : addr_q;
        cur_funct3 = (LATENCY == 0) ? req_funct3_i : funct3_q;
        cur_wdata  = (LATENCY == 0) ? req_wdata_i  : wdata_q;
    end

    always_comb begin
        if (cur_write) begin
            illegal = cur_funct3[2] | (cur_funct3 == 3'b011);
        end else begin
            illegal = (cur_funct3 == 3'b011) | (cur_funct3 == 3'b110) | (cur_funct3 == 3'b111);
        end
        misaligned   = ((cur_funct3[1:0] == 2'b01) & cur_addr[0]) |
                       ((cur_funct3[1:0] == 2'b10) & (cur_addr[1:0] != 2'b00));
        out_of_range = |cur_addr[31:AW+2];
        err          = illegal | misaligned | out_of_range;
    end

    assign word_idx = cur_addr[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    assign rd_half  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (cur_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        be      = 4'b0000;
        wr_data = cur_wdata;
        case (cur_funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << cur_addr[1:0];
                wr_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be      = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cur_wdata[15:0]}};
            end
            2'b10: begin
                be      = 4'b1111;
                wr_data = cur_wdata;
            end
            default: begin
                be      = 4'b0000;
                wr_data = cur_wdata;
            end
        endcase
    end

    // Gated by reset_ni too, since the array itself has no reset.
    assign mem_we = commit & cur_write & ~err & reset_ni;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rsp_rdata_o <= 32'd0;
            rsp_error_o <= 1'b0;
        end else if (commit) begin
            rsp_rdata_o <= (err | cur_write) ? 32'd0 : load_data;
            rsp_error_o <= err;
        end
    end

endmodule

// File: tb/tb_tiny5_dmem_responder.sv
// Self-checking bench for tiny5_dmem_responder: directed scenarios plus a random
// load/store mix compared against a byte-addressed reference memory.
module tb_tiny5_dmem_responder;

    localparam int DEPTH  = 1024;
    localparam int LAT    = 2;
    localparam int DEPTH0 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_error;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;

    logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_error;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [2:0]  z_req_funct3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_bytes [128];

    tiny5_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_funct3_i(req_funct3), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error)
    );

    tiny5_dmem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(0)) dut0 (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_write_i(z_req_write),
        .req_addr_i(z_req_addr), .req_funct3_i(z_req_funct3), .req_wdata_i(z_req_wdata),
        .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
        .rsp_rdata_o(z_rsp_rdata), .rsp_error_o(z_rsp_error)
    );

    // Drives one request on the main DUT and returns the response plus the number
    // of negedges from acceptance until rsp_valid was first seen (expected LAT+1).
    task automatic txn(input logic w, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd;
        rsp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_addr   = $urandom;
        req_funct3 = 3'($urandom);
        req_wdata  = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_error;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: valid=%b error=%b rdata=%h, required 0/0/0",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: ready=%b valid=%b z_ready=%b z_valid=%b, required 1/0/1/0",
                     req_ready, rsp_valid, z_req_ready, z_rsp_valid);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic er;
        int lat;
        txn(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b0 || lat !== LAT + 1) begin
            n_fail++;
            $display("[TB] FAIL sw_word: rdata=%h err=%b lat=%0d, required 0/0/%0d", rd, er, lat, LAT + 1);
        end
        txn(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== LAT + 1) begin
            n_fail++;
            $display("[TB] FAIL lw_word: rdata=%h err=%b lat=%0d, required deadbeef/0/%0d", rd, er, lat, LAT + 1);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd;
        logic er;
        int lat;
        logic [31:0] l_addr [5] = '{32'h20, 32'h21, 32'h21, 32'h22, 32'h22};
        logic [2:0]  l_f3   [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] l_exp  [5] = '{32'h8001AA44, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8001, 32'h00008001};
        txn(1'b1, 32'h30, 3'b010, 32'h0, rd, er, lat);
        txn(1'b1, 32'h20, 3'b010, 32'h11223344, rd, er, lat);
        txn(1'b1, 32'h21, 3'b000, 32'h555555AA, rd, er, lat);
        txn(1'b1, 32'h22, 3'b001, 32'h77778001, rd, er, lat);
        for (int i = 0; i < 5; i++) begin
            txn(1'b0, l_addr[i], l_f3[i], 32'd0, rd, er, lat);
            n_checks++;
            if (rd !== l_exp[i] || er !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL lane_load%0d: rdata=%h err=%b, required %h/0", i, rd, er, l_exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat;
        logic        e_w    [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] e_addr [6] = '{32'h13, 32'h25, 32'h24, 32'h24, 32'h40, 32'(4 * DEPTH)};
        logic [2:0]  e_f3   [6] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b011, 3'b010};
        logic [31:0] e_exp  [6] = '{32'd0, 32'd0, 32'd0, 32'hCAFEF00D, 32'd0, 32'd0};
        logic        e_err  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        txn(1'b1, 32'h24, 3'b010, 32'hCAFEF00D, rd, er, lat);
        for (int i = 0; i < 6; i++) begin
            txn(e_w[i], e_addr[i], e_f3[i], 32'h9999BEEF, rd, er, lat);
            n_checks++;
            if (rd !== e_exp[i] || er !== e_err[i]) begin
                n_fail++;
                $display("[TB] FAIL error_case%0d: rdata=%h err=%b, required %h/%b", i, rd, er, e_exp[i], e_err[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd0;
        logic er0;
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        rd0 = rsp_rdata;
        er0 = rsp_error;
        n_checks++;
        if (rsp_valid !== 1'b1 || rd0 !== 32'hDEADBEEF || er0 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_first: valid=%b rdata=%h err=%b, required 1/deadbeef/0", rsp_valid, rd0, er0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_error !== er0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL bp_hold%0d: valid=%b rdata=%h err=%b ready=%b, required 1/%h/%b/0",
                         i, rsp_valid, rsp_rdata, rsp_error, req_ready, rd0, er0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_release: valid=%b ready=%b, required 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic er;
        int lat;
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_funct3 = 3'b010;
        req_wdata = 32'h12345678;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_wait_reset: valid=%b rdata=%h err=%b, required 0/0/0", rsp_valid, rsp_rdata, rsp_error);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_wait_no_resp: valid=%b, required 0", rsp_valid);
        end
        reset_n = 1'b1;
        txn(1'b0, 32'h30, 3'b010, 32'd0, rd, er, lat);
        n_checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_wait_discard: rdata=%h err=%b, required 0/0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd;
        logic er, w, exp_er, illegal, mis, oor;
        logic [2:0] f3;
        int lat, n;
        longint val;
        for (int i = 0; i < 32; i++) begin
            wd = $urandom;
            txn(1'b1, 32'(4 * i), 3'b010, wd, rd, er, lat);
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = wd[8*b +: 8];
        end
        for (int t = 0; t < 80; t++) begin
            w  = 1'($urandom);
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2) | (w ? 0 : ($urandom_range(0, 1) << 2)));
            a  = ($urandom_range(0, 9) == 0) ? (32'h1000 + $urandom_range(0, 32'hFFFF)) : 32'($urandom_range(0, 127));
            wd = $urandom;
            illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            mis = (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
            oor = (a / 4) >= DEPTH;
            exp_er = illegal || mis || oor;
            exp_rd = 32'd0;
            if (!exp_er && w) begin
                for (int b = 0; b < n; b++) ref_bytes[a + b] = wd[8*b +: 8];
            end else if (!exp_er) begin
                val = 0;
                for (int b = 0; b < n; b++) val = val + (longint'(ref_bytes[a + b]) << (8 * b));
                if (f3 < 3'd4 && n < 4 && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
                exp_rd = val[31:0];
            end
            txn(w, a, f3, wd, rd, er, lat);
            n_checks++;
            if (rd !== exp_rd || er !== exp_er || lat !== LAT + 1) begin
                n_fail++;
                $display("[TB] FAIL random%0d w=%b f3=%0d a=%h: rdata=%h err=%b lat=%0d, required %h/%b/%0d",
                         t, w, f3, a, rd, er, lat, exp_rd, exp_er, LAT + 1);
            end
        end
    endtask

    // Zero-latency build with req_valid and rsp_ready held high: 5 stores then 5 loads.
    task automatic test_latency0();
        logic [31:0] d [5];
        logic [31:0] expd [10];
        int idx, ridx, cycles;
        logic acc, prev_acc;
        for (int i = 0; i < 5; i++) begin
            d[i] = $urandom;
            expd[i] = 32'd0;
            expd[i + 5] = d[i];
        end
        @(negedge clk);
        idx = 0; ridx = 0; cycles = 0; prev_acc = 1'b0;
        z_req_valid = 1'b1; z_rsp_ready = 1'b1;
        z_req_write = 1'b1; z_req_addr = 32'd0; z_req_funct3 = 3'b010; z_req_wdata = d[0];
        while (ridx < 10 && cycles < 100) begin
            if (prev_acc) begin
                n_checks++;
                if (z_rsp_valid !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL lat0_valid%0d: valid=%b, required 1", idx - 1, z_rsp_valid);
                end
            end
            if (z_rsp_valid) begin
                n_checks++;
                if (z_rsp_rdata !== expd[ridx] || z_rsp_error !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL lat0_data%0d: rdata=%h err=%b, required %h/0", ridx, z_rsp_rdata, z_rsp_error, expd[ridx]);
                end
                ridx++;
            end
            acc = z_req_valid & z_req_ready;
            @(posedge clk);
            cycles++;
            @(negedge clk);
            prev_acc = acc;
            if (acc) begin
                idx++;
                if (idx < 10) begin
                    z_req_write  = (idx < 5);
                    z_req_addr   = 32'(4 * (idx % 5));
                    z_req_wdata  = (idx < 5) ? d[idx] : 32'hFFFFFFFF;
                end else begin
                    z_req_valid = 1'b0;
                end
            end
        end
        n_checks++;
        if (cycles !== 20 || ridx !== 10) begin
            n_fail++;
            $display("[TB] FAIL lat0_throughput: cycles=%0d responses=%0d, required 20/10", cycles, ridx);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0;
        req_wdata = 32'd0; rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 32'd0; z_req_funct3 = 3'd0;
        z_req_wdata = 32'd0; z_rsp_ready = 1'b1;
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        test_latency0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
